// File: rtl/emergency_request_arbiter_if.sv
// Request/grant bundle between the emergency arbiter and its environment.
// The master side drives the requests and enable; the slave is the arbiter.
interface emergency_request_arbiter_if;
  logic       vsw;
  logic [3:0] emergency_req;
  logic [3:0] Emergency_green;
  logic       grant_active;
  logic       timeout;
  logic [3:0] pending;

  modport master (
    output vsw,
    output emergency_req,
    input  Emergency_green,
    input  grant_active,
    input  timeout,
    input  pending
  );

  modport slave (
    input  vsw,
    input  emergency_req,
    output Emergency_green,
    output grant_active,
    output timeout,
    output pending
  );
endinterface

// File: rtl/emergency_request_arbiter.sv
// Emergency request conditioner: sync, debounce, round-robin grant with
// minimum hold, maximum grant time, lockout and post-grant cooldown.
module emergency_request_arbiter #(
  parameter int FREQUENCY        = 2,
  parameter int DEBOUNCE_CYCLES  = 4,
  parameter int HOLD_SECONDS     = 3,
  parameter int MAX_SECONDS      = 8,
  parameter int COOLDOWN_SECONDS = 2
) (
  input logic clk,
  input logic reset,
  emergency_request_arbiter_if.slave bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW = (FREQUENCY > 1) ? $clog2(FREQUENCY) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] COOL  = 2'd2;

  logic [3:0]         s1_q, s1_d;
  logic [3:0]         s2_q, s2_d;
  logic [3:0]         deb_q, deb_d;
  logic [3:0][CW-1:0] dcnt_q, dcnt_d;
  logic [3:0]         lock_q, lock_d;
  logic [3:0]         pend_q, pend_d;
  logic [1:0]         state_q, state_d;
  logic [1:0]         win_q, win_d;
  logic [1:0]         rr_q, rr_d;
  logic [SW-1:0]      sub_q, sub_d;
  logic [7:0]         el_q, el_d;
  logic [3:0]         green_q, green_d;
  logic               act_q, act_d;
  logic               to_q, to_d;

  logic [3:0] pend_c;
  logic [1:0] pick;
  logic [1:0] idx;
  logic       tick;

  always_comb begin
    s1_d   = bus.emergency_req;
    s2_d   = s1_q;
    deb_d  = deb_q;
    dcnt_d = dcnt_q;
    for (int b = 0; b < 4; b++) begin
      if (s2_q[b] != deb_q[b]) begin
        if (dcnt_q[b] == CW'(DEBOUNCE_CYCLES - 1)) begin
          deb_d[b]  = s2_q[b];
          dcnt_d[b] = '0;
        end else begin
          dcnt_d[b] = dcnt_q[b] + CW'(1);
        end
      end else begin
        dcnt_d[b] = '0;
      end
    end
  end

  // Round-robin: first pending road after the last winner; the
  // last winner itself is the lowest-priority candidate.
  always_comb begin
    pend_c = deb_q & ~lock_q;
    pick   = rr_q;
    idx    = '0;
    for (int i = 4; i >= 1; i--) begin
      idx = rr_q + 2'(i);
      if (pend_c[idx]) pick = idx;
    end
  end

  assign tick = (sub_q == SW'(FREQUENCY - 1));

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    rr_d    = rr_q;
    lock_d  = lock_q & deb_q;
    pend_d  = pend_c;
    to_d    = 1'b0;
    sub_d   = tick ? '0 : sub_q + SW'(1);
    el_d    = (tick && el_q != 8'hFF) ? el_q + 8'd1 : el_q;
    unique case (state_q)
      IDLE: begin
        if (bus.vsw && |pend_c) begin
          state_d = GRANT;
          win_d   = pick;
          rr_d    = pick;
          sub_d   = '0;
          el_d    = '0;
        end
      end
      GRANT: begin
        if (!bus.vsw) begin
          state_d = IDLE;
        end else if (tick && el_q == 8'(MAX_SECONDS - 1)) begin
          state_d       = COOL;
          to_d          = 1'b1;
          lock_d[win_q] = 1'b1;
          sub_d         = '0;
          el_d          = '0;
        end else if (el_q >= 8'(HOLD_SECONDS) && !deb_q[win_q]) begin
          state_d = COOL;
          sub_d   = '0;
          el_d    = '0;
        end
      end
      COOL: begin
        if (!bus.vsw) begin
          state_d = IDLE;
        end else if (tick && el_q == 8'(COOLDOWN_SECONDS - 1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    green_d = (state_d == GRANT) ? (4'b0001 << win_d) : 4'b0000;
    act_d   = (state_d == GRANT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q    <= '0;
      s2_q    <= '0;
      deb_q   <= '0;
      dcnt_q  <= '0;
      lock_q  <= '0;
      pend_q  <= '0;
      state_q <= IDLE;
      win_q   <= '0;
      rr_q    <= 2'd3;
      sub_q   <= '0;
      el_q    <= '0;
      green_q <= '0;
      act_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      deb_q   <= deb_d;
      dcnt_q  <= dcnt_d;
      lock_q  <= lock_d;
      pend_q  <= pend_d;
      state_q <= state_d;
      win_q   <= win_d;
      rr_q    <= rr_d;
      sub_q   <= sub_d;
      el_q    <= el_d;
      green_q <= green_d;
      act_q   <= act_d;
      to_q    <= to_d;
    end
  end

  assign bus.Emergency_green = green_q;
  assign bus.grant_active    = act_q;
  assign bus.timeout         = to_q;
  assign bus.pending         = pend_q;

endmodule

// File: tb/tb_emergency_request_arbiter.sv
// Bench for emergency_request_arbiter: vector table, directed corner
// sequences and random traffic against a cycle-level reference model.
module tb_emergency_request_arbiter;

  localparam int F    = 2;
  localparam int DEB  = 4;
  localparam int HOLD = 3;
  localparam int MAXS = 8;
  localparam int CD   = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;

  emergency_request_arbiter_if bus();

  emergency_request_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // reference model state
  logic [3:0] m_s1 = '0, m_s2 = '0, m_deb = '0, m_lock = '0;
  logic [3:0] m_hist [4];
  int         m_st = 0, m_cnt = 0, m_win = 0, m_rr = 3;
  logic [3:0] m_green = '0, m_pend = '0;
  logic       m_act = 1'b0, m_to = 1'b0;

  typedef struct {
    logic       rst;
    logic       vsw;
    logic [3:0] req;
    logic [3:0] green;
    logic       act;
    logic       to;
    logic [3:0] pend;
  } vec_t;

  vec_t tbl [18];

  function automatic logic [9:0] dut_out();
    return {bus.Emergency_green, bus.grant_active, bus.timeout,
            bus.pending};
  endfunction

  task automatic check(input string name, input logic [9:0] got,
                       input logic [9:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, got, exp);
    end
  endtask

  // One edge of the specification's behaviour, from pre-edge values.
  task automatic model_step();
    logic [3:0] pend, nd, nl;
    bit flip;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_deb = '0; m_lock = '0;
      for (int j = 0; j < 4; j++) m_hist[j] = '0;
      m_st = 0; m_cnt = 0; m_win = 0; m_rr = 3;
      m_green = '0; m_act = 1'b0; m_to = 1'b0; m_pend = '0;
    end else begin
      pend = m_deb & ~m_lock;
      for (int j = 3; j > 0; j--) m_hist[j] = m_hist[j-1];
      m_hist[0] = m_s2;
      nd = m_deb;
      for (int b = 0; b < 4; b++) begin
        flip = 1;
        for (int j = 0; j < DEB; j++)
          if (m_hist[j][b] == m_deb[b]) flip = 0;
        if (flip) nd[b] = ~m_deb[b];
      end
      nl = m_lock & m_deb;
      m_to = 1'b0;
      case (m_st)
        0: if (bus.vsw && pend != 0) begin
          for (int i = 1; i <= 4; i++)
            if (pend[(m_rr + i) % 4]) begin
              m_win = (m_rr + i) % 4;
              break;
            end
          m_rr = m_win; m_st = 1; m_cnt = 0;
        end
        1: if (!bus.vsw) m_st = 0;
           else if (m_cnt + 1 == MAXS * F) begin
             m_to = 1'b1; nl[m_win] = 1'b1; m_st = 2; m_cnt = 0;
           end else if (m_cnt / F >= HOLD && !m_deb[m_win]) begin
             m_st = 2; m_cnt = 0;
           end else m_cnt++;
        default: if (!bus.vsw) m_st = 0;
           else if (m_cnt + 1 == CD * F) m_st = 0;
           else m_cnt++;
      endcase
      m_green = (m_st == 1) ? 4'(1 << m_win) : 4'b0000;
      m_act   = (m_st == 1);
      m_pend  = pend;
      m_s2    = m_s1;
      m_s1    = bus.emergency_req;
      m_deb   = nd;
      m_lock  = nl;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check("model", dut_out(), {m_green, m_act, m_to, m_pend});
  endtask

  task automatic wait_green(input logic [3:0] want, input int budget,
                            output int n);
    n = 0;
    while (bus.Emergency_green !== want && n < budget) begin
      step();
      n++;
    end
    check("wait_green", {6'd0, bus.Emergency_green}, {6'd0, want});
  endtask

  int n, len;
  bit saw;

  initial begin
    bus.vsw = 1'b1;
    bus.emergency_req = 4'b0000;
    for (int j = 0; j < 4; j++) m_hist[j] = '0;

    tbl[0] = '{1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000};
    for (int i = 1; i <= 2; i++)
      tbl[i] = '{1'b0, 1'b1, 4'b0010, 4'b0000, 1'b0, 1'b0, 4'b0000};
    for (int i = 3; i <= 8; i++)
      tbl[i] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000};
    for (int i = 9; i <= 14; i++)
      tbl[i] = '{1'b0, 1'b1, 4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0000};
    for (int i = 15; i <= 17; i++)
      tbl[i] = '{1'b0, 1'b1, 4'b0001, 4'b0001, 1'b1, 1'b0, 4'b0001};

    // reset, north glitch, east latency to first grant
    for (int i = 0; i < 18; i++) begin
      reset = tbl[i].rst;
      bus.vsw = tbl[i].vsw;
      bus.emergency_req = tbl[i].req;
      step();
      check("table", dut_out(), {tbl[i].green, tbl[i].act, tbl[i].to,
                                 tbl[i].pend});
    end

    // early drop: grant held at least HOLD seconds, no timeout
    bus.emergency_req = 4'b0000;
    len = 3; saw = 0;
    while (bus.Emergency_green == 4'b0001 && len < 40) begin
      step();
      if (bus.timeout) saw = 1;
      if (bus.Emergency_green == 4'b0001) len++;
    end
    check("hold_min", 10'(len >= HOLD * F && len < MAXS * F), 10'd1);
    check("hold_no_to", 10'(saw), 10'd0);
    repeat (8) step();

    // east+west together: east first, times out after 16 cycles
    reset = 1'b1; step(); reset = 1'b0;
    bus.emergency_req = 4'b0101;
    wait_green(4'b0001, 20, n);
    len = 0;
    while (bus.Emergency_green == 4'b0001 && len < 40) begin
      step();
      len++;
    end
    check("to_len", 10'(len), 10'(MAXS * F));
    check("to_pulse", 10'(bus.timeout), 10'd1);
    step();
    check("to_one_cycle", 10'(bus.timeout), 10'd0);
    wait_green(4'b0100, 20, n);
    check("cool_gap", 10'(n + 1 >= CD * F), 10'd1);

    // west also times out; east stays locked while held
    len = 0;
    while (bus.Emergency_green == 4'b0100 && len < 40) begin
      step();
      len++;
    end
    check("west_len", 10'(len), 10'(MAXS * F));
    bus.emergency_req = 4'b0001;
    saw = 0;
    repeat (60) begin
      step();
      if (bus.Emergency_green != 4'b0000) saw = 1;
    end
    check("lockout", 10'(saw), 10'd0);
    bus.emergency_req = 4'b0000;
    repeat (DEB + 4) step();
    bus.emergency_req = 4'b0001;
    wait_green(4'b0001, 20, n);

    // vsw off mid-grant, then back on
    bus.vsw = 1'b0;
    step();
    check("vsw_off", {6'd0, bus.Emergency_green}, 10'd0);
    repeat (4) begin
      step();
      check("vsw_held", {6'd0, bus.Emergency_green}, 10'd0);
    end
    bus.vsw = 1'b1;
    step();
    check("vsw_on", {6'd0, bus.Emergency_green}, 10'b0001);

    // one-cycle reset mid-grant
    reset = 1'b1;
    step();
    check("rst_mid", dut_out(), 10'd0);
    reset = 1'b0;
    wait_green(4'b0001, 20, n);
    check("rst_regrant", 10'(n), 10'(DEB + 3));

    // random traffic against the model
    reset = 1'b1; step(); reset = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 24) == 0)
          bus.emergency_req[b] = ~bus.emergency_req[b];
      if ($urandom_range(0, 149) == 0) bus.vsw = ~bus.vsw;
      if (!bus.vsw && $urandom_range(0, 19) == 0) bus.vsw = 1'b1;
      reset = ($urandom_range(0, 999) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
